imm_gen_stage: RTL
==================

Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage between fetch and decode.
- Accepts an instruction word with its PC and produces three results: the fully sign-extended immediate for all RV32I/RV64I formats (I, S, B, U, J), a format code, and the PC-relative target (pc + imm).
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so neither ready path is combinationally coupled.

Parameters:
- XLEN, 32, datapath width for immediate, PC and target; legal values 32 or 64.
- RV64, 0, when 1 also decodes OP-IMM-32 (0011011) as I-format; only legal with XLEN=64.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept; equals (state != FULL).
- in_inst  input  32  instruction word.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_inst  output  32  instruction of the head entry.
- out_pc  output  XLEN  PC of the head entry.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.

Behaviour:
- Reset: state=EMPTY; out_valid=0, in_ready=1; out_inst, out_pc, out_imm, out_fmt and out_target are all 0. Reset asserted mid-operation discards both entries immediately.
- Decode is combinational on in_inst; results are written into the entry at push.
- Opcode map (inst[6:0]):
  - I-format: 0000011, 0010011, 1100111, 1110011, and 0011011 when RV64=1.
  - S-format: 0100011.
  - B-format: 1100011.
  - U-format: 0110111, 0010111.
  - J-format: 1101111.
  - Anything else: NONE with imm=0.
- Immediate layouts, all sign-extended from inst[31] to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Latency is 1 cycle: an entry pushed at edge N shows out_valid=1 after edge N when the buffer was empty.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- State machine (entries held: EMPTY=0, HALF=1, FULL=2):
  - EMPTY: push -> HALF.
  - HALF: push only -> FULL; pop only -> EMPTY; push and pop together -> HALF, new entry becomes head.
  - FULL: pop -> HALF and the skid entry moves to head. No push is possible because in_ready=0.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- out_valid = (state != EMPTY). in_ready depends only on registered state.
- in_valid is sampled only when in_ready=1. Inputs with in_valid=0 are ignored.

Optional Feature:
- Macro: IMM_GEN_ILLEGAL_EN.
- When defined:
  - Adds output port out_illegal (1 bit), stored per entry.
  - out_illegal is set when inst[1:0] != 2'b11, when the opcode is unmapped, or when opcode 0011011 arrives with RV64=0.
  - For illegal entries: out_imm=0, out_fmt=0, out_target=out_pc.
  - out_illegal resets to 0.
- When not defined: the port is absent, and unmapped opcodes produce NONE, imm=0, with no flag.

Test Plan:
- I-format: push 0xFFF00093, pc 0x0, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_target=0xFFFFFFFF.
- S-format then B-format, back-to-back:
  - 0xFE20AE23 -> out_imm=0xFFFFFFFC, fmt=2.
  - 0xFE000CE3 with pc 0x100 -> out_imm=0xFFFFFFF8, fmt=3, out_target=0x000000F8.
- U/J-format:
  - 0x123452B7 -> out_imm=0x12345000, fmt=4.
  - 0x0010006F with pc 0x1000 -> out_imm=0x00000800, fmt=5, out_target=0x1800.
- Backpressure:
  - out_ready=0, offer A,B,C -> A and B accepted; in_ready=0 after B; C held upstream.
  - Raise out_ready -> outputs A, B, C in order, one per cycle; none lost or duplicated.
- Reset with FULL buffer:
  - Assert rst asynchronously -> out_valid=0 and in_ready=1 immediately; all outputs 0.
  - After deassert, push 0x0010006F -> clean single output.
- XLEN=64, RV64=1: push 0xFFF0009B -> out_imm=0xFFFFFFFFFFFFFFFF, fmt=1.
- Illegal handling (run once with IMM_GEN_ILLEGAL_EN defined, once without):
  - Push 0x0000007F -> with macro: out_illegal=1, out_imm=0. Without macro: fmt=0, imm=0.

Source files
------------

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32I/RV64I immediate generator with
// valid/ready handshakes and a 2-entry skid buffer (EMPTY/HALF/FULL).
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_inst/in_pc
// upstream; out_valid/out_ready/out_inst/out_pc/out_imm/out_fmt/
// out_target downstream (+ out_illegal when IMM_GEN_ILLEGAL_EN defined).
// out_fmt: 0=NONE 1=I 2=S 3=B 4=U 5=J. out_target = out_pc + out_imm.
module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int RV64 = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
`ifdef IMM_GEN_ILLEGAL_EN
  output logic            out_illegal,
`endif
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            ill;
`endif
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, skid_q, dec;
  logic   push, pop;
  logic   ld_head, ld_skid, mv_skid;

  logic [6:0]      op;
  logic            is_i, is_s, is_b, is_u, is_j;
  logic [31:0]     imm32;
  logic [XLEN-1:0] sext;

  assign op   = in_inst[6:0];
  assign is_i = (op == 7'b0000011) || (op == 7'b0010011)
             || (op == 7'b1100111) || (op == 7'b1110011)
             || ((RV64 != 0) && (op == 7'b0011011));
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) || (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);

  always_comb begin
    imm32   = '0;
    dec     = '0;
    dec.fmt = FMT_NONE;
    unique case (1'b1)
      is_i: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.fmt = FMT_I;
      end
      is_s: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:25],
                   in_inst[11:7]};
        dec.fmt = FMT_S;
      end
      is_b: begin
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                   in_inst[30:25], in_inst[11:8], 1'b0};
        dec.fmt = FMT_B;
      end
      is_u: begin
        imm32   = {in_inst[31:12], 12'b0};
        dec.fmt = FMT_U;
      end
      is_j: begin
        imm32   = {{11{in_inst[31]}}, in_inst[31],
                   in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
        dec.fmt = FMT_J;
      end
      default: begin
        imm32   = '0;
        dec.fmt = FMT_NONE;
      end
    endcase
    // Widen from bit 31 so one path serves XLEN=32 and 64.
    sext       = {XLEN{imm32[31]}};
    sext[31:0] = imm32;
    dec.inst   = in_inst;
    dec.pc     = in_pc;
    dec.imm    = sext;
    dec.target = in_pc + sext;
`ifdef IMM_GEN_ILLEGAL_EN
    // Every mapped opcode ends in 2'b11, so NONE covers all cases.
    dec.ill    = (dec.fmt == FMT_NONE);
`endif
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    ld_head = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = HALF;
          ld_head = 1'b1;
        end
      end
      HALF: begin
        if (push && !pop) begin
          state_d = FULL;
          ld_skid = 1'b1;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          ld_head = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = HALF;
          mv_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ld_head) begin
        head_q <= dec;
      end else if (mv_skid) begin
        head_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign out_inst   = head_q.inst;
  assign out_pc     = head_q.pc;
  assign out_imm    = head_q.imm;
  assign out_fmt    = head_q.fmt;
  assign out_target = head_q.target;
`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal = head_q.ill;
`endif

endmodule
